shift_normalizer: RTL

- Sequential inverse of the team's 16-bit left/right shifter: given a word, it recovers the shift amount that aligns the word.
- It shifts the word one position per clock until the leading bit in the chosen direction is 1.
- It returns the aligned word and the shift count. It feeds later normalise and priority logic, and it is checked by passing its outputs back through the shifter.
- Start/done handshake, one shift per cycle.

---
 rtl/shift_normalizer_pkg.sv | 20 ++
 rtl/shift_normalizer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the shift normaliser.
//
// WIDTH        : data word width in bits
// AMT_W        : width of the shift-count output, $clog2(WIDTH)
// norm_state_t : controller states IDLE / SHIFT / DONE
// word_t       : one data word
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/shift_normalizer.sv
// Sequential normaliser: shifts a captured word one bit per clock until the
// leading bit in the requested direction is 1, and reports how many shifts
// were needed. It undoes the team's left/right shifter: shifting Y back by
// amt in the opposite direction restores the original word.
//
// State table
//   IDLE  | waiting for start; outputs hold the previous result
//   SHIFT | testing the target bit, shifting once per cycle until it is 1
//   DONE  | result valid, done pulses for this one cycle
//
// Ports
//   clk   in   system clock, rising edge
//   reset in   asynchronous, active-high reset
//   start in   request pulse, sampled only in IDLE
//   A     in   word to normalise, captured with an accepted start
//   ir    in   direction: 0 = shift right to Y[0], 1 = shift left to Y[WIDTH-1]
//   busy  out  high in SHIFT and DONE
//   done  out  one-cycle result-valid pulse
//   Y     out  normalised word (working register while busy)
//   amt   out  number of single-bit shifts performed
//   zero  out  the captured word was all zeros
module shift_normalizer
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic             ir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [AMT_W-1:0] amt,
    output logic             zero
);

    norm_state_t      state;
    norm_state_t      state_nxt;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] count;
    logic             dir;
    logic             zero_q;
    logic             target;

    // Bit that must become 1 for the word to count as aligned.
    always_comb begin
        target = 1'b0;
        if (dir) begin
            target = work[WIDTH-1];
        end else begin
            target = work[0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // An all-zero word can never align, so skip SHIFT.
                    state_nxt = (A == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (target) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture on an accepted start, one logical shift per SHIFT
    // cycle while the target bit is still 0. Everything else holds, which
    // keeps the last result visible in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work   <= '0;
            count  <= '0;
            dir    <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= A;
                        dir    <= ir;
                        count  <= '0;
                        zero_q <= (A == '0);
                    end
                end
                SHIFT: begin
                    if (!target) begin
                        if (dir) begin
                            work <= {work[WIDTH-2:0], 1'b0};
                        end else begin
                            work <= {1'b0, work[WIDTH-1:1]};
                        end
                        count <= count + AMT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign Y    = work;
    assign amt  = count;
    assign zero = zero_q;

endmodule
